jtkcpu_intseq: RTL and testbench

JTKCPU_INTSEQ -- requirements
Module: jtkcpu_intseq

---
 rtl/jtkcpu_intseq.sv | 138 +++++++++++++
 tb/tb_jtkcpu_intseq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_intseq.sv
// Interrupt sequencer: synchronizes NMI/FIRQ/IRQ, arbitrates them and
// drives the control unit through request, service and CWAI/SYNC wait.
module jtkcpu_intseq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       nmi_n,
    input  logic       firq_n,
    input  logic       irq_n,
    input  logic       cc_f,
    input  logic       cc_i,
    input  logic       nmi_arm,
    input  logic       ni,
    input  logic       ack,
    input  logic       done,
    input  logic       wait_cwai,
    input  logic       wait_sync,
    output logic       int_req,
    output logic [3:0] intvec,
    output logic       full_stk,
    output logic       wake,
    output logic       busy,
    output logic       set_f,
    output logic       set_i
);

    typedef enum logic [1:0] {IDLE, REQ, SVC, WAIT} state_t;
    typedef enum logic [1:0] {SEL_NMI, SEL_FIRQ, SEL_IRQ} sel_t;

    state_t     state_q, state_d;
    sel_t       sel_q, sel_d, win;
    logic       mode_q, mode_d;
    logic       wake_q, wake_d;
    logic       pend_q, pend_d;
    logic       armed_q, armed_d;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic       nmi_last_q, nmi_last_d;
    logic       nmi_fall, firq_p, irq_p, any_p, any_line;

    // bit 2 = NMI, bit 1 = FIRQ, bit 0 = IRQ
    always_comb begin
        sync1_d    = {nmi_n, firq_n, irq_n};
        sync2_d    = sync1_q;
        nmi_last_d = sync2_q[2];
        nmi_fall   = nmi_last_q & ~sync2_q[2];
        firq_p     = ~sync2_q[1] & ~cc_f;
        irq_p      = ~sync2_q[0] & ~cc_i;
        any_p      = pend_q | firq_p | irq_p;
        any_line   = ~&sync2_q;
        if (pend_q)      win = SEL_NMI;
        else if (firq_p) win = SEL_FIRQ;
        else             win = SEL_IRQ;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        wake_d  = 1'b0;
        armed_d = armed_q | nmi_arm;
        pend_d  = pend_q;
        if (state_q == REQ && ack && sel_q == SEL_NMI) pend_d = 1'b0;
        // A new edge wins over the clear so it is never lost
        if (nmi_fall && armed_q) pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (ni && any_p) begin
                    state_d = REQ;
                    sel_d   = win;
                end else if (wait_cwai || wait_sync) begin
                    state_d = WAIT;
                    mode_d  = wait_sync;
                end
            end
            REQ: if (ack) state_d = SVC;
            SVC: if (done) state_d = IDLE;
            WAIT: begin
                if (any_p) begin
                    state_d = REQ;
                    sel_d   = win;
                end else if (mode_q && any_line) begin
                    state_d = IDLE;
                    wake_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= SEL_IRQ;
            mode_q     <= 1'b0;
            wake_q     <= 1'b0;
            pend_q     <= 1'b0;
            armed_q    <= 1'b0;
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            nmi_last_q <= 1'b1;
        end else if (cen) begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            wake_q     <= wake_d;
            pend_q     <= pend_d;
            armed_q    <= armed_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            nmi_last_q <= nmi_last_d;
        end
    end

    always_comb begin
        int_req  = 1'b0;
        intvec   = 4'hE;
        full_stk = 1'b0;
        set_f    = 1'b0;
        set_i    = 1'b0;
        wake     = wake_q;
        busy     = state_q != IDLE;
        if (state_q == REQ || state_q == SVC) begin
            case (sel_q)
                SEL_NMI:  intvec = 4'hC;
                SEL_FIRQ: intvec = 4'h6;
                default:  intvec = 4'h8;
            endcase
            full_stk = sel_q != SEL_FIRQ;
        end
        if (state_q == REQ) int_req = 1'b1;
        if (state_q == SVC) begin
            set_i = 1'b1;
            set_f = sel_q != SEL_IRQ;
        end
    end

endmodule

// File: tb/tb_jtkcpu_intseq.sv
// Directed bench for jtkcpu_intseq: NMI arming, masking, priority,
// CWAI/SYNC waits and reset during service.
module tb_jtkcpu_intseq;

    logic       clk = 1'b0;
    logic       rst_n, cen, nmi_n, firq_n, irq_n, cc_f, cc_i;
    logic       nmi_arm, ni, ack, done, wait_cwai, wait_sync;
    logic       int_req, full_stk, wake, busy, set_f, set_i;
    logic [3:0] intvec;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    jtkcpu_intseq dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
        .cc_f(cc_f), .cc_i(cc_i), .nmi_arm(nmi_arm), .ni(ni),
        .ack(ack), .done(done),
        .wait_cwai(wait_cwai), .wait_sync(wait_sync),
        .int_req(int_req), .intvec(intvec), .full_stk(full_stk),
        .wake(wake), .busy(busy), .set_f(set_f), .set_i(set_i)
    );

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ni;
        ni = 1'b1; tick(1); ni = 1'b0;
    endtask

    task automatic ack_done;
        ack = 1'b1; tick(1); ack = 1'b0;
        done = 1'b1; tick(1); done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1;
        nmi_n = 1'b1; firq_n = 1'b1; irq_n = 1'b1;
        cc_f = 1'b1; cc_i = 1'b1; nmi_arm = 1'b0; ni = 1'b0;
        ack = 1'b0; done = 1'b0; wait_cwai = 1'b0; wait_sync = 1'b0;
        tick(2);
        chk("rst int_req", int_req, 0);
        chk("rst intvec", intvec, 4'hE);
        chk("rst full_stk", full_stk, 0);
        chk("rst busy", busy, 0);
        chk("rst wake", wake, 0);
        rst_n = 1'b1;
        tick(2);

        // NMI edge while disarmed is dropped
        nmi_n = 1'b0; tick(4);
        pulse_ni;
        chk("nmi unarmed int_req", int_req, 0);
        chk("nmi unarmed busy", busy, 0);
        nmi_n = 1'b1; tick(3);
        nmi_arm = 1'b1; tick(1); nmi_arm = 1'b0;
        nmi_n = 1'b0; tick(4);
        pulse_ni;
        chk("nmi int_req", int_req, 1);
        chk("nmi intvec", intvec, 4'hC);
        chk("nmi full_stk", full_stk, 1);
        cen = 1'b0; ack = 1'b1; tick(1);
        chk("cen hold int_req", int_req, 1);
        cen = 1'b1; tick(1); ack = 1'b0;
        chk("nmi svc int_req", int_req, 0);
        chk("nmi svc intvec", intvec, 4'hC);
        chk("nmi svc set_f", set_f, 1);
        chk("nmi svc set_i", set_i, 1);
        done = 1'b1; tick(1); done = 1'b0;
        chk("nmi done busy", busy, 0);
        pulse_ni;
        chk("nmi pend cleared", int_req, 0);
        nmi_n = 1'b1; tick(3);

        // Masked IRQ, then unmasked
        irq_n = 1'b0; cc_i = 1'b1; tick(4);
        pulse_ni;
        chk("irq masked int_req", int_req, 0);
        cc_i = 1'b0;
        pulse_ni;
        chk("irq int_req", int_req, 1);
        chk("irq intvec", intvec, 4'h8);
        chk("irq full_stk", full_stk, 1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("irq svc set_f", set_f, 0);
        chk("irq svc set_i", set_i, 1);
        done = 1'b1; tick(1); done = 1'b0;
        irq_n = 1'b1; cc_i = 1'b1; tick(3);

        // FIRQ beats IRQ; a later NMI does not change the frozen choice
        firq_n = 1'b0; irq_n = 1'b0; cc_f = 1'b0; cc_i = 1'b0;
        tick(3);
        pulse_ni;
        chk("firq intvec", intvec, 4'h6);
        chk("firq full_stk", full_stk, 0);
        nmi_n = 1'b0; tick(3);
        chk("firq frozen intvec", intvec, 4'h6);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("firq svc set_f", set_f, 1);
        chk("firq svc set_i", set_i, 1);
        done = 1'b1; tick(1); done = 1'b0;
        firq_n = 1'b1; irq_n = 1'b1; cc_f = 1'b1; cc_i = 1'b1;
        tick(3);
        pulse_ni;
        chk("latched nmi intvec", intvec, 4'hC);
        ack_done;
        nmi_n = 1'b1; tick(3);

        // SYNC wake on a masked line
        irq_n = 1'b0; cc_i = 1'b1; tick(3);
        wait_sync = 1'b1; tick(1); wait_sync = 1'b0;
        chk("sync busy", busy, 1);
        chk("sync wake early", wake, 0);
        tick(1);
        chk("sync wake", wake, 1);
        chk("sync idle", busy, 0);
        chk("sync int_req", int_req, 0);
        tick(1);
        chk("sync wake once", wake, 0);
        irq_n = 1'b1; tick(3);

        // CWAI releases on FIRQ without ni
        cc_f = 1'b0;
        wait_cwai = 1'b1; tick(1); wait_cwai = 1'b0;
        chk("cwai busy", busy, 1);
        chk("cwai no req", int_req, 0);
        firq_n = 1'b0; tick(3);
        chk("cwai int_req", int_req, 1);
        chk("cwai intvec", intvec, 4'h6);
        ack_done;
        firq_n = 1'b1; cc_f = 1'b1; tick(3);

        // Reset in the middle of service
        irq_n = 1'b0; cc_i = 1'b0; tick(3);
        pulse_ni;
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("pre-rst set_i", set_i, 1);
        rst_n = 1'b0; #1;
        chk("svc rst int_req", int_req, 0);
        chk("svc rst intvec", intvec, 4'hE);
        chk("svc rst full_stk", full_stk, 0);
        chk("svc rst set_f", set_f, 0);
        chk("svc rst set_i", set_i, 0);
        chk("svc rst wake", wake, 0);
        chk("svc rst busy", busy, 0);
        irq_n = 1'b1; cc_i = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post-rst busy", busy, 0);
        chk("post-rst intvec", intvec, 4'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
